// File: rtl/mpt_pkg.sv
// Shared MPT types: access/permission encodings, PLB request and entry layouts,
// and the reserved-permission helper shared by the PLB and the walker.
package mpt_pkg;

    localparam int XLEN             = 32;
    localparam int SDID_LEN         = 6;
    localparam int PLB_RANGE_SHIFT  = 16;
    localparam int PLB_PAGE_SEL_LSB = 12;
    localparam int PLB_PAGES        = 16;
    localparam int PLB_TAG_W        = XLEN - PLB_RANGE_SHIFT;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } mpt_access_e;

    // bit0 = read, bit1 = write, bit2 = exec; write without read is reserved
    typedef enum logic [2:0] {
        PERM_RSVD_000 = 3'b000,
        ALLOW_R       = 3'b001,
        PERM_RSVD_010 = 3'b010,
        ALLOW_RW      = 3'b011,
        ALLOW_X       = 3'b100,
        ALLOW_RX      = 3'b101,
        PERM_RSVD_110 = 3'b110,
        ALLOW_RWX     = 3'b111
    } mpt_permissions_e;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        logic [XLEN-1:0]     spa;
        mpt_access_e         access_type;
    } plb_lookup_req_t;

    typedef struct packed {
        logic                               valid;
        logic [SDID_LEN-1:0]                sdid;
        logic [PLB_TAG_W-1:0]               tag;
        mpt_permissions_e [PLB_PAGES-1:0]   perms;
    } plb_range_entry_t;

    function automatic logic perm_is_reserved(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b010) || (p == 3'b110);
    endfunction

endpackage

// File: rtl/mpt_perm_check.sv
// Combinational permission check: 3-bit page permissions against an access type.
// Reserved encodings and ACCESS_NONE always deny.
module mpt_perm_check
    import mpt_pkg::*;
(
    input  mpt_permissions_e perms_i,
    input  mpt_access_e      access_i,
    output logic             allow_o
);

    logic [2:0] p;
    assign p = perms_i;

    always_comb begin
        allow_o = 1'b0;
        if (!perm_is_reserved(p)) begin
            case (access_i)
                ACCESS_READ:  allow_o = p[0];
                ACCESS_WRITE: allow_o = p[1];
                ACCESS_EXEC:  allow_o = p[2];
                default:      allow_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mpt_plb.sv
// Permission Lookaside Buffer: caches leaf MPT range entries (16 pages each),
// one-cycle registered lookup response. Optional counters: MPT_PLB_PERF_CNT_EN.
module mpt_plb
    import mpt_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int TAG_W       = XLEN - PLB_RANGE_SHIFT,
    parameter int PTR_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          lookup_valid_i,
    output logic                          lookup_ready_o,
    input  plb_lookup_req_t               lookup_req_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic                          resp_hit_o,
    output logic [2:0]                    resp_perms_o,
    output logic                          resp_allow_o,
`ifdef MPT_PLB_PERF_CNT_EN
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o,
`endif
    input  logic                          fill_valid_i,
    input  logic [SDID_LEN-1:0]           fill_sdid_i,
    input  logic [XLEN-1:0]               fill_spa_i,
    input  mpt_permissions_e [PLB_PAGES-1:0] fill_perms_i,
    input  logic                          flush_i,
    input  logic                          flush_sdid_en_i,
    input  logic [SDID_LEN-1:0]           flush_sdid_i
);

    plb_range_entry_t ent_q [NUM_ENTRIES];
    plb_range_entry_t ent_d [NUM_ENTRIES];
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic       resp_vld_q, resp_vld_d;
    logic       resp_hit_q, resp_hit_d;
    logic       resp_allow_q, resp_allow_d;
    logic [2:0] resp_perms_q, resp_perms_d;

    logic [TAG_W-1:0] lk_tag, fill_tag;
    logic [3:0]       lk_page;
    logic             lookup_fire, lk_hit, lk_perm_ok, lk_allow;
    mpt_permissions_e lk_perms;

    logic             fill_match, free_found;
    logic [PTR_W-1:0] match_idx, free_idx, tgt_idx;

    logic unused_spa_bits;
    assign unused_spa_bits = ^{lookup_req_i.spa[PLB_PAGE_SEL_LSB-1:0],
                               fill_spa_i[PLB_RANGE_SHIFT-1:0]};

    assign lk_tag   = lookup_req_i.spa[XLEN-1:PLB_RANGE_SHIFT];
    assign lk_page  = lookup_req_i.spa[PLB_RANGE_SHIFT-1:PLB_PAGE_SEL_LSB];
    assign fill_tag = fill_spa_i[XLEN-1:PLB_RANGE_SHIFT];

    // No lookup is taken during a flush so nothing stale can be answered after it.
    assign lookup_ready_o = !flush_i && (!resp_vld_q || resp_ready_i);
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;

    always_comb begin
        lk_hit   = 1'b0;
        lk_perms = PERM_RSVD_000;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].valid && (ent_q[i].sdid == lookup_req_i.sdid) &&
                (ent_q[i].tag == lk_tag)) begin
                lk_hit   = 1'b1;
                lk_perms = ent_q[i].perms[lk_page];
            end
        end
    end

    mpt_perm_check u_perm_check (
        .perms_i  (lk_perms),
        .access_i (lookup_req_i.access_type),
        .allow_o  (lk_perm_ok)
    );

    assign lk_allow = lk_hit && lk_perm_ok;

    always_comb begin
        resp_vld_d   = resp_vld_q;
        resp_hit_d   = resp_hit_q;
        resp_perms_d = resp_perms_q;
        resp_allow_d = resp_allow_q;
        if (lookup_fire) begin
            resp_vld_d   = 1'b1;
            resp_hit_d   = lk_hit;
            resp_perms_d = lk_perms;
            resp_allow_d = lk_allow;
        end else if (resp_ready_i) begin
            resp_vld_d = 1'b0;
        end
    end

    // Scan high to low so the lowest matching / lowest free index wins.
    always_comb begin
        ent_d      = ent_q;
        rr_ptr_d   = rr_ptr_q;
        fill_match = 1'b0;
        free_found = 1'b0;
        match_idx  = '0;
        free_idx   = '0;
        tgt_idx    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].valid && (ent_q[i].sdid == fill_sdid_i) &&
                (ent_q[i].tag == fill_tag)) begin
                fill_match = 1'b1;
                match_idx  = PTR_W'(i);
            end
            if (!ent_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
        end
        if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (!flush_sdid_en_i || (ent_q[i].sdid == flush_sdid_i)) begin
                    ent_d[i].valid = 1'b0;
                end
            end
        end else if (fill_valid_i) begin
            if (fill_match) begin
                ent_d[match_idx].perms = fill_perms_i;
            end else begin
                tgt_idx = free_found ? free_idx : rr_ptr_q;
                if (!free_found) begin
                    rr_ptr_d = rr_ptr_q + PTR_W'(1);
                end
                ent_d[tgt_idx].valid = 1'b1;
                ent_d[tgt_idx].sdid  = fill_sdid_i;
                ent_d[tgt_idx].tag   = fill_tag;
                ent_d[tgt_idx].perms = fill_perms_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            resp_vld_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_perms_q <= 3'b000;
            resp_allow_q <= 1'b0;
        end else begin
            ent_q        <= ent_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_vld_q   <= resp_vld_d;
            resp_hit_q   <= resp_hit_d;
            resp_perms_q <= resp_perms_d;
            resp_allow_q <= resp_allow_d;
        end
    end

    assign resp_valid_o = resp_vld_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_perms_o = resp_perms_q;
    assign resp_allow_o = resp_allow_q;

`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_i && !flush_sdid_en_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (lookup_fire) begin
            if (lk_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!lk_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mpt_plb.sv
// Scoreboard bench for mpt_plb: directed lookups push expected responses, a
// monitor pops and compares on each response handshake.
module tb_mpt_plb;
    import mpt_pkg::*;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic                        lookup_valid_i;
    logic                        lookup_ready_o;
    plb_lookup_req_t             lookup_req_i;
    logic                        resp_valid_o;
    logic                        resp_ready_i;
    logic                        resp_hit_o;
    logic [2:0]                  resp_perms_o;
    logic                        resp_allow_o;
    logic                        fill_valid_i;
    logic [SDID_LEN-1:0]         fill_sdid_i;
    logic [XLEN-1:0]             fill_spa_i;
    mpt_permissions_e [15:0]     fill_perms_i;
    logic                        flush_i;
    logic                        flush_sdid_en_i;
    logic [SDID_LEN-1:0]         flush_sdid_i;
`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0]                 hit_cnt_o;
    logic [31:0]                 miss_cnt_o;
`endif

    typedef struct packed {
        logic       hit;
        logic [2:0] perms;
        logic       allow;
    } exp_t;

    exp_t                    sb[$];
    exp_t                    mon_e;
    int                      total = 0;
    int                      bad = 0;
    int                      stalls = 0;
    mpt_permissions_e [15:0] pv;

    always #5 clk_i = ~clk_i;

    mpt_plb #(.NUM_ENTRIES(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_ready_o  (lookup_ready_o),
        .lookup_req_i    (lookup_req_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_hit_o      (resp_hit_o),
        .resp_perms_o    (resp_perms_o),
        .resp_allow_o    (resp_allow_o),
`ifdef MPT_PLB_PERF_CNT_EN
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o),
`endif
        .fill_valid_i    (fill_valid_i),
        .fill_sdid_i     (fill_sdid_i),
        .fill_spa_i      (fill_spa_i),
        .fill_perms_i    (fill_perms_i),
        .flush_i         (flush_i),
        .flush_sdid_en_i (flush_sdid_en_i),
        .flush_sdid_i    (flush_sdid_i)
    );

    always @(negedge clk_i) begin
        if (!rst_i && resp_valid_o && resp_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got hit=%0b perms=%0b allow=%0b, want no response",
                         resp_hit_o, resp_perms_o, resp_allow_o);
            end else begin
                mon_e = sb.pop_front();
                if ({resp_hit_o, resp_perms_o, resp_allow_o} !== mon_e) begin
                    bad++;
                    $display("FAIL resp_%0d: got hit=%0b perms=%03b allow=%0b, want hit=%0b perms=%03b allow=%0b",
                             total, resp_hit_o, resp_perms_o, resp_allow_o,
                             mon_e.hit, mon_e.perms, mon_e.allow);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic uni(input mpt_permissions_e p);
        for (int i = 0; i < 16; i++) pv[i] = p;
    endtask

    task automatic fill(input logic [SDID_LEN-1:0] sd, input logic [XLEN-1:0] spa);
        fill_valid_i = 1'b1;
        fill_sdid_i  = sd;
        fill_spa_i   = spa;
        fill_perms_i = pv;
        @(posedge clk_i); #1;
        fill_valid_i = 1'b0;
    endtask

    task automatic flush(input logic en, input logic [SDID_LEN-1:0] sd);
        flush_i         = 1'b1;
        flush_sdid_en_i = en;
        flush_sdid_i    = sd;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
    endtask

    task automatic lookup(input logic [SDID_LEN-1:0] sd, input logic [XLEN-1:0] spa,
                          input mpt_access_e acc, input logic eh, input logic [2:0] ep,
                          input logic ea);
        int waits = 0;
        lookup_valid_i           = 1'b1;
        lookup_req_i.sdid        = sd;
        lookup_req_i.spa         = spa;
        lookup_req_i.access_type = acc;
        @(negedge clk_i);
        while (!lookup_ready_o && waits < 40) begin
            waits++;
            @(negedge clk_i);
        end
        stalls += waits;
        total++;
        if (!lookup_ready_o) begin
            bad++;
            $display("FAIL lookup_accept: ready=0 after %0d cycles, want 1", waits);
        end else begin
            sb.push_back('{hit: eh, perms: ep, allow: ea});
        end
        @(posedge clk_i); #1;
        lookup_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        resp_ready_i = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i           = 1'b1;
        lookup_valid_i  = 1'b0;
        lookup_req_i    = '0;
        resp_ready_i    = 1'b1;
        fill_valid_i    = 1'b0;
        fill_sdid_i     = '0;
        fill_spa_i      = '0;
        uni(PERM_RSVD_000);
        fill_perms_i    = pv;
        flush_i         = 1'b0;
        flush_sdid_en_i = 1'b0;
        flush_sdid_i    = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        check("rst_resp_valid", 32'(resp_valid_o), 0);
        check("rst_resp_hit", 32'(resp_hit_o), 0);
        check("rst_resp_perms", 32'(resp_perms_o), 0);
        check("rst_resp_allow", 32'(resp_allow_o), 0);
        check("rst_lookup_ready", 32'(lookup_ready_o), 1);
`ifdef MPT_PLB_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt_o, 0);
        check("rst_miss_cnt", miss_cnt_o, 0);
`endif
        @(posedge clk_i); #1;

        // Cold miss, then page selection and permission decoding
        lookup(6'd3, 32'h0001_2000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        uni(PERM_RSVD_000);
        pv[2] = ALLOW_RX;
        pv[4] = PERM_RSVD_110;
        pv[5] = ALLOW_RWX;
        fill(6'd3, 32'h0001_0000);
        lookup(6'd3, 32'h0001_2000, ACCESS_EXEC,  1'b1, 3'b101, 1'b1);
        lookup(6'd3, 32'h0001_2000, ACCESS_WRITE, 1'b1, 3'b101, 1'b0);
        lookup(6'd3, 32'h0001_2abc, ACCESS_READ,  1'b1, 3'b101, 1'b1);
        lookup(6'd3, 32'h0001_2000, ACCESS_NONE,  1'b1, 3'b101, 1'b0);
        lookup(6'd3, 32'h0001_3000, ACCESS_READ,  1'b1, 3'b000, 1'b0);
        lookup(6'd3, 32'h0001_4000, ACCESS_EXEC,  1'b1, 3'b110, 1'b0);
        lookup(6'd3, 32'h0001_5000, ACCESS_WRITE, 1'b1, 3'b111, 1'b1);
        lookup(6'd4, 32'h0001_2000, ACCESS_EXEC,  1'b0, 3'b000, 1'b0);
        lookup(6'd3, 32'h0002_2000, ACCESS_EXEC,  1'b0, 3'b000, 1'b0);
        drain();

        // Lookup in the same cycle as a fill sees the pre-fill state
        uni(ALLOW_R);
        fill_valid_i = 1'b1;
        fill_sdid_i  = 6'd3;
        fill_spa_i   = 32'h0003_0000;
        fill_perms_i = pv;
        lookup(6'd3, 32'h0003_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        fill_valid_i = 1'b0;
        lookup(6'd3, 32'h0003_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);

        // Flush in the same cycle as a fill drops the fill
        fill_valid_i = 1'b1;
        fill_sdid_i  = 6'd3;
        fill_spa_i   = 32'h0004_0000;
        fill_perms_i = pv;
        flush(1'b1, 6'd9);
        fill_valid_i = 1'b0;
        lookup(6'd3, 32'h0004_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup(6'd3, 32'h0003_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
        drain();

        // Replacement: 9 ranges into 8 entries, then in-place refill
        flush(1'b0, 6'd0);
        uni(ALLOW_R);
        for (int r = 0; r < 9; r++) fill(6'd1, (32'h10 + 32'(r)) << 16);
        lookup(6'd1, 32'h0010_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup(6'd1, 32'h0011_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
        lookup(6'd1, 32'h0018_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
        uni(ALLOW_RWX);
        fill(6'd1, 32'h0012_0000);
        lookup(6'd1, 32'h0012_0000, ACCESS_WRITE, 1'b1, 3'b111, 1'b1);
        uni(ALLOW_R);
        fill(6'd1, 32'h0019_0000);
        lookup(6'd1, 32'h0011_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
        lookup(6'd1, 32'h0012_0000, ACCESS_WRITE, 1'b1, 3'b111, 1'b1);
        lookup(6'd1, 32'h0019_0000, ACCESS_READ,  1'b1, 3'b001, 1'b1);
        lookup(6'd1, 32'h0013_0000, ACCESS_READ,  1'b1, 3'b001, 1'b1);
        drain();

        // Per-SDID flush, then flush all
        flush(1'b0, 6'd0);
        uni(ALLOW_R);
        fill(6'd1, 32'h0002_0000);
        fill(6'd2, 32'h0002_0000);
        flush(1'b1, 6'd1);
        lookup(6'd1, 32'h0002_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup(6'd2, 32'h0002_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
        flush(1'b0, 6'd0);
        lookup(6'd1, 32'h0002_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup(6'd2, 32'h0002_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        drain();

`ifdef MPT_PLB_PERF_CNT_EN
        flush(1'b0, 6'd0);
        uni(ALLOW_RX);
        fill(6'd7, 32'h0070_0000);
        lookup(6'd7, 32'h0070_0000, ACCESS_READ,  1'b1, 3'b101, 1'b1);
        lookup(6'd7, 32'h0070_1000, ACCESS_EXEC,  1'b1, 3'b101, 1'b1);
        lookup(6'd7, 32'h007f_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
        lookup(6'd7, 32'h0070_f000, ACCESS_WRITE, 1'b1, 3'b101, 1'b0);
        lookup(6'd8, 32'h0070_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
        drain();
        check("perf_hit_cnt", hit_cnt_o, 3);
        check("perf_miss_cnt", miss_cnt_o, 2);
`endif

        // Held response stays stable across a fill and a flush
        flush(1'b0, 6'd0);
        uni(ALLOW_RW);
        fill(6'd5, 32'h0005_0000);
        resp_ready_i = 1'b0;
        lookup(6'd5, 32'h0005_3000, ACCESS_READ, 1'b1, 3'b011, 1'b1);
        lookup_valid_i           = 1'b1;
        lookup_req_i.access_type = ACCESS_WRITE;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                uni(ALLOW_X);
                fill_valid_i = 1'b1;
                fill_sdid_i  = 6'd5;
                fill_spa_i   = 32'h0005_0000;
                fill_perms_i = pv;
            end
            if (k == 3) begin
                flush_i         = 1'b1;
                flush_sdid_en_i = 1'b0;
            end
            @(negedge clk_i);
            check("hold_valid", 32'(resp_valid_o), 1);
            check("hold_hit", 32'(resp_hit_o), 1);
            check("hold_perms", 32'(resp_perms_o), 32'b011);
            check("hold_allow", 32'(resp_allow_o), 1);
            check("hold_lookup_ready", 32'(lookup_ready_o), 0);
            @(posedge clk_i); #1;
            fill_valid_i = 1'b0;
            flush_i      = 1'b0;
        end
        lookup_valid_i = 1'b0;

        // Release: held response drains while a new range is filled
        uni(ALLOW_RX);
        fill_valid_i = 1'b1;
        fill_sdid_i  = 6'd5;
        fill_spa_i   = 32'h0006_0000;
        fill_perms_i = pv;
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        fill_valid_i = 1'b0;
        stalls = 0;
        lookup(6'd5, 32'h0006_0000, ACCESS_EXEC,  1'b1, 3'b101, 1'b1);
        lookup(6'd5, 32'h0005_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
        lookup(6'd5, 32'h0006_1000, ACCESS_WRITE, 1'b1, 3'b101, 1'b0);
        lookup(6'd5, 32'h0006_2000, ACCESS_READ,  1'b1, 3'b101, 1'b1);
        check("b2b_stalls", 32'(stalls), 0);
        drain();

        // Reset while a response is held
        resp_ready_i = 1'b0;
        lookup(6'd5, 32'h0006_0000, ACCESS_READ, 1'b1, 3'b101, 1'b1);
        check("pre_rst_valid", 32'(resp_valid_o), 1);
`ifdef MPT_PLB_PERF_CNT_EN
        check("pre_rst_hit_cnt", hit_cnt_o, 4);
        check("pre_rst_miss_cnt", miss_cnt_o, 1);
`endif
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(resp_valid_o), 0);
        check("mid_rst_hit", 32'(resp_hit_o), 0);
        check("mid_rst_perms", 32'(resp_perms_o), 0);
        check("mid_rst_allow", 32'(resp_allow_o), 0);
`ifdef MPT_PLB_PERF_CNT_EN
        check("mid_rst_hit_cnt", hit_cnt_o, 0);
        check("mid_rst_miss_cnt", miss_cnt_o, 0);
`endif
        sb.delete();
        @(posedge clk_i); #1;
        rst_i        = 1'b0;
        resp_ready_i = 1'b1;
        lookup(6'd5, 32'h0006_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        drain();

        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpt_plb.md
# mpt_plb

Parametrised Permission Lookaside Buffer (PLB) for the MPT checker. It caches leaf MPT entries, one 64 KiB range of 16 pages per entry, tagged by SDID and range number. It answers permission lookups with one cycle of latency and a registered, back-pressurable response. It sits between the transaction pipeline and the MPT walker: hits bypass the walk, misses go to the walker, and the walker's result is written back through the fill port.

## Interface
Parameters:
- NUM_ENTRIES, 8: entry count; power of two, 2..64.
- TAG_W, XLEN-16: range-number width, spa bits [XLEN-1:16].
- PTR_W, $clog2(NUM_ENTRIES): replacement pointer width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- lookup_valid_i  in  1  lookup request valid.
- lookup_ready_o  out  1  lookup accepted when valid && ready.
- lookup_req_i  in  plb_lookup_req_t  SDID, spa, access_type.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_hit_o  out  1  tag match found.
- resp_perms_o  out  3  selected page permissions; 0 on miss.
- resp_allow_o  out  1  access permitted; 0 on miss.
- fill_valid_i  in  1  write a leaf entry, always accepted.
- fill_sdid_i  in  SDID_LEN  fill SDID.
- fill_spa_i  in  XLEN  any address inside the range.
- fill_perms_i  in  16x mpt_permissions_e  leaf PERMS field.
- flush_i  in  1  invalidate request, one cycle.
- flush_sdid_en_i  in  1  1: flush only the matching SDID; 0: flush all.
- flush_sdid_i  in  SDID_LEN  SDID to flush.

## Operation
- Entry contents: valid bit, SDID, tag, and perms[15:0][2:0].
- Hit condition: valid && SDID == req.SDID && tag == spa[XLEN-1:16]. At most one entry can hit.
- Page select: perms[spa[15:12]].
- Permission check: READ needs bit0, WRITE needs bit1, EXEC needs bit2.
- Deny cases:
  - ACCESS_NONE gives allow=0.
  - Reserved encodings 3'b000, 3'b010 and 3'b110 deny every access.
- Fill, existing tag: if SDID and tag already match, perms are overwritten in place. No duplicate entry is ever created.
- Fill, new tag: the entry is allocated to the lowest-index invalid entry. If all entries are valid, it goes to the entry at rr_ptr, and rr_ptr then increments modulo NUM_ENTRIES. rr_ptr moves only on full-buffer allocation.
- Flush: clears the valid bit of every selected entry in the same cycle. rr_ptr is unchanged.
- Flush vs fill in the same cycle: flush wins and the fill is dropped. The walker refetches.
- Lookup vs fill in the same cycle: the lookup sees pre-fill state, so a miss on the range being filled is correct.

## Timing
- Reset values: resp_valid_o=0, resp_hit_o=0, resp_perms_o=0, resp_allow_o=0, all entries invalid, rr_ptr=0. lookup_ready_o=1 after reset.
- Lookup latency: a lookup accepted in cycle N produces its response in cycle N+1.
- lookup_ready_o = !flush_i && (!resp_valid_o || resp_ready_i). This gives full throughput with no bubble.
- Holding rule: while resp_valid_o && !resp_ready_i, all resp_* outputs hold stable, including across fills and flushes. A held response is never revoked.
- Flush cycle: no lookup is accepted during a flush, so no stale permission issues after it. The first post-flush lookup is accepted in the cycle after flush_i.
- Fill visibility: a fill in cycle N is visible to a lookup accepted in cycle N+1.
- Reset mid-operation: all state clears immediately and the pending response is discarded.

## Configuration
- MPT_PLB_PERF_CNT_EN, when defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each counts accepted lookups and saturates at 32'hFFFF_FFFF.
  - Both reset to 0 and clear on flush_i with flush_sdid_en_i=0.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Structure
- Shared mpt_pkg holds:
  - plb_lookup_req_t and mpt_permissions_e (existing).
  - New plb_range_entry_t: valid, SDID, tag, perms.
  - New PLB_RANGE_SHIFT=16 and PLB_PAGE_SEL_LSB=12.
- Sub-module mpt_perm_check: combinational function of 3-bit perms and mpt_access_e to allow, including the reserved-encoding deny. The walker reuses it.

## Test plan
- Reset, then lookup SDID 3, spa 0x0001_2000, READ -> next cycle resp_valid=1, hit=0, perms=0, allow=0.
- Fill SDID 3, spa 0x0001_0000 with perms[2]=ALLOW_RX, then lookup 0x0001_2000: EXEC gives hit=1, perms=3'b101, allow=1; WRITE gives hit=1, allow=0.
- Fill 9 distinct ranges into NUM_ENTRIES=8 -> the ninth replaces entry 0 and rr_ptr=1; refill of range 2 updates in place and rr_ptr stays 1.
- Fill SDID 1 and SDID 2 at the same spa, flush with flush_sdid_en=1 and SDID 1 -> SDID 1 misses, SDID 2 hits; flush_all -> both miss.
- Hold resp_ready_i=0 for 5 cycles with a fill and flush applied -> resp_* stable and lookup_ready_o=0; on release, back-to-back lookups complete one per cycle.
- With MPT_PLB_PERF_CNT_EN: 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; assert rst_i mid-response -> resp_valid_o=0 and counters=0.
